// File: rtl/cmos_raw8_capture_pkg.sv
// Shared types and helpers for the CMOS RAW8 capture front-end.
//   cap_state_e : capture sequencer states (sync to frame gap, skip frames, run)
//   sat_inc11   : 11-bit saturating increment used by the geometry counters
//   sat_inc8    : 8-bit saturating increment used by the frame-rate counter
package cmos_raw8_capture_pkg;

  typedef enum logic [1:0] {
    StSync = 2'd0,
    StSkip = 2'd1,
    StRun  = 2'd2
  } cap_state_e;

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7ff) ? v : v + 11'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cmos_raw8_capture_fps_counter.sv
// Frame-rate meter: counts frame ends inside a free-running window of CLK_FREQ clk cycles.
//   clk           in  pixel clock
//   rst           in  asynchronous active-high reset
//   frame_end     in  one-cycle pulse per completed frame
//   cmos_fps_rate out frames counted in the last completed window (saturates at 255)
module cmos_fps_counter
  import cmos_raw8_capture_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 24_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_end,
  output logic [7:0] cmos_fps_rate
);

  localparam int unsigned WinW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [WinW-1:0] WinLast = WinW'(CLK_FREQ - 1);

  logic [WinW-1:0] win_q, win_d;
  logic [7:0]      frm_q, frm_d;
  logic [7:0]      rate_q, rate_d;
  logic [7:0]      frm_inc;

  always_comb begin
    // A frame end on the boundary cycle belongs to the window that is closing.
    frm_inc = frame_end ? sat_inc8(frm_q) : frm_q;
    win_d   = win_q + WinW'(1);
    frm_d   = frm_inc;
    rate_d  = rate_q;
    if (win_q == WinLast) begin
      win_d  = '0;
      frm_d  = 8'd0;
      rate_d = frm_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q  <= '0;
      frm_q  <= 8'd0;
      rate_q <= 8'd0;
    end else begin
      win_q  <= win_d;
      frm_q  <= frm_d;
      rate_q <= rate_d;
    end
  end

  assign cmos_fps_rate = rate_q;

endmodule

// File: rtl/cmos_raw8_capture.sv
// CMOS RAW8 capture front-end: registers the sensor interface, normalises vsync to
// active-high, drops the first FRAME_SKIP complete frames, then passes frame-aligned
// vsync/href/data on to the Bayer interpolator. Also checks frame geometry and
// measures the frame rate.
//   clk, rst                in  pixel clock, asynchronous active-high reset
//   cmos_vsync/href/data    in  raw sensor interface
//   cmos_frame_vsync/href   out gated, active-high frame/line valid (2-cycle latency)
//   cmos_frame_data         out gated pixel data, 0 outside valid pixels
//   capture_en              out high once frames are being passed through
//   frame_err               out one-cycle pulse at frame end on a geometry mismatch
//   cmos_fps_rate           out frames counted in the last measurement window
module cmos_raw8_capture
  import cmos_raw8_capture_pkg::*;
#(
  parameter logic        CMOS_VSYNC_VALID = 1'b1,
  parameter logic [9:0]  IMG_HDISP        = 10'd640,
  parameter logic [9:0]  IMG_VDISP        = 10'd480,
  parameter logic [3:0]  FRAME_SKIP       = 4'd10,
  parameter int unsigned CLK_FREQ         = 24_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmos_vsync,
  input  logic       cmos_href,
  input  logic [7:0] cmos_data,
  output logic       cmos_frame_vsync,
  output logic       cmos_frame_href,
  output logic [7:0] cmos_frame_data,
  output logic       capture_en,
  output logic       frame_err,
  output logic [7:0] cmos_fps_rate
);

  // Input stage
  logic       vs_in;
  logic       vs_d1_q, vs_d2_q;
  logic       href_d1_q, href_d2_q;
  logic [7:0] data_d1_q, data_d2_q;
  // Tracks that d2 holds real pin data rather than reset values.
  logic [1:0] fill_q;

  assign vs_in = CMOS_VSYNC_VALID ? cmos_vsync : ~cmos_vsync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d1_q   <= 1'b0;
      vs_d2_q   <= 1'b0;
      href_d1_q <= 1'b0;
      href_d2_q <= 1'b0;
      data_d1_q <= 8'd0;
      data_d2_q <= 8'd0;
      fill_q    <= 2'b00;
    end else begin
      vs_d1_q   <= vs_in;
      vs_d2_q   <= vs_d1_q;
      href_d1_q <= cmos_href;
      href_d2_q <= href_d1_q;
      data_d1_q <= cmos_data;
      data_d2_q <= data_d1_q;
      fill_q    <= {fill_q[0], 1'b1};
    end
  end

  logic frame_start, frame_end, line_end;
  assign frame_start = vs_d1_q & ~vs_d2_q;
  assign frame_end   = ~vs_d1_q & vs_d2_q;
  assign line_end    = ~href_d1_q & href_d2_q;

  // Capture sequencer
  cap_state_e state_q, state_d;
  logic [3:0] skip_q, skip_d;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    case (state_q)
      StSync: begin
        // Only a genuine vsync-inactive sample counts, so a reset released mid-frame
        // waits for that frame to finish before any counting starts.
        if (fill_q[1] && !vs_d2_q) begin
          skip_d  = 4'd0;
          state_d = (FRAME_SKIP == 4'd0) ? StRun : StSkip;
        end
      end
      StSkip: begin
        if (frame_end) begin
          skip_d = skip_q + 4'd1;
          if (skip_d == FRAME_SKIP) begin
            state_d = StRun;
          end
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StSync;
      skip_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  logic run;
  logic href_gate;
  assign run       = (state_q == StRun);
  assign href_gate = href_d2_q & vs_d2_q & run;

  // Geometry check
  logic [10:0] pix_q, pix_d, pix_inc;
  logic [10:0] line_q, line_d, line_inc;
  logic        h_bad_q, h_bad_d, h_bad_now;
  logic        line_end_v;

  always_comb begin
    // Lines outside vsync are ignored entirely.
    line_end_v = line_end & vs_d2_q & run;
    // Include the current cycle's pixel/line so the last pixel of a line and a line
    // ending on the frame-end cycle are both accounted for.
    pix_inc    = href_gate ? sat_inc11(pix_q) : pix_q;
    line_inc   = line_end_v ? sat_inc11(line_q) : line_q;
    h_bad_now  = h_bad_q | (line_end_v & (pix_inc != {1'b0, IMG_HDISP}));
    pix_d      = 11'd0;
    line_d     = 11'd0;
    h_bad_d    = 1'b0;
    if (run) begin
      pix_d   = line_end_v ? 11'd0 : pix_inc;
      line_d  = frame_start ? 11'd0 : line_inc;
      h_bad_d = frame_start ? 1'b0 : h_bad_now;
    end
    frame_err = run & frame_end & (h_bad_now | (line_inc != {1'b0, IMG_VDISP}));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_q   <= 11'd0;
      line_q  <= 11'd0;
      h_bad_q <= 1'b0;
    end else begin
      pix_q   <= pix_d;
      line_q  <= line_d;
      h_bad_q <= h_bad_d;
    end
  end

  // Outputs come straight from cleared flops, so they drop as soon as rst rises.
  assign cmos_frame_vsync = vs_d2_q & run;
  assign cmos_frame_href  = href_gate;
  assign cmos_frame_data  = href_gate ? data_d2_q : 8'd0;
  assign capture_en       = run;

  cmos_fps_counter #(
    .CLK_FREQ(CLK_FREQ)
  ) u_fps (
    .clk          (clk),
    .rst          (rst),
    .frame_end    (frame_end),
    .cmos_fps_rate(cmos_fps_rate)
  );

endmodule
